// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline control types: MEM-wait FSM states, the x0 register index,
// and the per-stage enable/flush bundle consumed by the stage registers.
package pipe_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pcEn;
        logic ifIdEn;
        logic ifIdFlush;
        logic idExEn;
        logic idExFlush;
        logic exMemEn;
        logic memWbFlush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // A load into x0 never produces a value, so it can never cause a stall.
    function automatic logic loadUseHazard(
        input logic       memRead,
        input logic [4:0] rdAddr,
        input logic [4:0] rs1Addr,
        input logic [4:0] rs2Addr,
        input logic       useRs1,
        input logic       useRs2
    );
        return memRead && (rdAddr != REG_X0) &&
               ((useRs1 && (rs1Addr == rdAddr)) || (useRs2 && (rs2Addr == rdAddr)));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stage-control outputs of the stall/flush scheduler.
// The master side drives the hazard sources; the controller is the slave.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             EX_memRead;
    logic [4:0]       EX_rd_addr;
    logic [4:0]       ID_rs1_addr;
    logic [4:0]       ID_rs2_addr;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic             EX_redirect;
    logic             MEM_req;
    logic             MEM_ack;

    logic             PC_en;
    logic             IF_ID_en;
    logic             IF_ID_flush;
    logic             ID_EX_en;
    logic             ID_EX_flush;
    logic             EX_MEM_en;
    logic             MEM_WB_flush;
    logic             mem_wait;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output EX_memRead, EX_rd_addr, ID_rs1_addr, ID_rs2_addr, ID_use_rs1, ID_use_rs2,
               EX_redirect, MEM_req, MEM_ack,
        input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush,
               mem_wait, timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  EX_memRead, EX_rd_addr, ID_rs1_addr, ID_rs2_addr, ID_use_rs1, ID_use_rs2,
               EX_redirect, MEM_req, MEM_ack,
        output PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush,
               mem_wait, timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: MEM-wait freeze with timeout,
// EX redirect flush and load-use bubble, plus saturating event counters.
module pipeline_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              timeoutErr_q;

    logic        loadUse;
    logic        tmo;
    logic        frz;
    logic        stallInc;
    logic        flushInc;
    stage_ctrl_t ctrl;

    assign loadUse = loadUseHazard(bus.EX_memRead, bus.EX_rd_addr, bus.ID_rs1_addr,
                                   bus.ID_rs2_addr, bus.ID_use_rs1, bus.ID_use_rs2);
    assign tmo     = (state_q == ST_WAIT) && (wcnt_q == WCNT_W'(TIMEOUT - 1));
    assign frz     = bus.MEM_req && !bus.MEM_ack && !tmo;

    // Any cycle that is not frozen returns to RUN, so a timeout releases exactly like an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wcnt_q       <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            if (frz) begin
                state_q <= ST_WAIT;
                wcnt_q  <= (state_q == ST_RUN) ? WCNT_W'(1) : wcnt_q + 1'b1;
            end else begin
                state_q <= ST_RUN;
                wcnt_q  <= '0;
            end
            if (tmo && bus.MEM_req && !bus.MEM_ack) begin
                timeoutErr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl     = CTRL_RUN;
        stallInc = 1'b0;
        flushInc = 1'b0;
        if (!rst) begin
            if (frz) begin
                ctrl = CTRL_FREEZE;
            end else if (bus.EX_redirect) begin
                ctrl     = CTRL_REDIRECT;
                flushInc = 1'b1;
            end else if (loadUse) begin
                ctrl     = CTRL_LOADUSE;
                stallInc = 1'b1;
            end
        end
    end

    assign bus.PC_en        = ctrl.pcEn;
    assign bus.IF_ID_en     = ctrl.ifIdEn;
    assign bus.IF_ID_flush  = ctrl.ifIdFlush;
    assign bus.ID_EX_en     = ctrl.idExEn;
    assign bus.ID_EX_flush  = ctrl.idExFlush;
    assign bus.EX_MEM_en    = ctrl.exMemEn;
    assign bus.MEM_WB_flush = ctrl.memWbFlush;
    assign bus.mem_wait     = (state_q == ST_WAIT);
    assign bus.timeout_err  = timeoutErr_q;

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stallInc),
        .count_o (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flushInc),
        .count_o (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Model state: cycles already spent frozen on the current access (0 = running).
    int   mdlWait    = 0;
    bit   mdlErr     = 1'b0;
    int   mdlStall   = 0;
    int   mdlFlush   = 0;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks mid-cycle, then advances the model at the edge.
    task automatic applyStimulus(input bit r, input bit memRead, input int rd, input int rs1,
                                 input int rs2, input bit use1, input bit use2,
                                 input bit redir, input bit req, input bit ack);
        bit lu, tmo, frz;
        bit ePc, eIfId, eIfIdF, eIdEx, eIdExF, eExMem, eMemWbF;
        rst                 = r;
        bus.EX_memRead      = memRead;
        bus.EX_rd_addr      = 5'(rd);
        bus.ID_rs1_addr     = 5'(rs1);
        bus.ID_rs2_addr     = 5'(rs2);
        bus.ID_use_rs1      = use1;
        bus.ID_use_rs2      = use2;
        bus.EX_redirect     = redir;
        bus.MEM_req         = req;
        bus.MEM_ack         = ack;
        #4;
        lu  = memRead && (rd != 0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        tmo = (mdlWait > 0) && (mdlWait == TIMEOUT - 1);
        frz = !r && req && !ack && !tmo;
        {ePc, eIfId, eIfIdF, eIdEx, eIdExF, eExMem, eMemWbF} = 7'b1101010;
        if (frz) {ePc, eIfId, eIfIdF, eIdEx, eIdExF, eExMem, eMemWbF} = 7'b0000001;
        else if (!r && redir) {ePc, eIfId, eIfIdF, eIdEx, eIdExF, eExMem, eMemWbF} = 7'b1111110;
        else if (!r && lu) {ePc, eIfId, eIfIdF, eIdEx, eIdExF, eExMem, eMemWbF} = 7'b0001110;
        checkOutput("PC_en", 32'(bus.PC_en), 32'(ePc));
        checkOutput("IF_ID_en", 32'(bus.IF_ID_en), 32'(eIfId));
        checkOutput("IF_ID_flush", 32'(bus.IF_ID_flush), 32'(eIfIdF));
        checkOutput("ID_EX_en", 32'(bus.ID_EX_en), 32'(eIdEx));
        checkOutput("ID_EX_flush", 32'(bus.ID_EX_flush), 32'(eIdExF));
        checkOutput("EX_MEM_en", 32'(bus.EX_MEM_en), 32'(eExMem));
        checkOutput("MEM_WB_flush", 32'(bus.MEM_WB_flush), 32'(eMemWbF));
        checkOutput("mem_wait", 32'(bus.mem_wait), 32'(mdlWait > 0));
        checkOutput("timeout_err", 32'(bus.timeout_err), 32'(mdlErr));
        checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(mdlStall));
        checkOutput("flush_cnt", 32'(bus.flush_cnt), 32'(mdlFlush));
        @(posedge clk);
        if (r) begin
            mdlWait  = 0;
            mdlErr   = 1'b0;
            mdlStall = 0;
            mdlFlush = 0;
        end else begin
            if (!frz && redir) mdlFlush = (mdlFlush < CNT_MAX) ? mdlFlush + 1 : CNT_MAX;
            else if (!frz && lu) mdlStall = (mdlStall < CNT_MAX) ? mdlStall + 1 : CNT_MAX;
            if (tmo && req && !ack) mdlErr = 1'b1;
            mdlWait = frz ? mdlWait + 1 : 0;
        end
        #1;
    endtask

    initial begin
        bit pending;
        bit req, ack;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 5, 5, 0, 1, 0, 1, 1, 0);

        // Load-use on x5, then the non-stalling variants (rd=x0, use bit clear).
        applyStimulus(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
        checkOutput("luStallCnt", 32'(bus.stall_cnt), 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 5, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 7, 0, 1, 0, 0, 0);
        checkOutput("luStallCnt2", 32'(bus.stall_cnt), 32'd2);

        // Load-use coinciding with a redirect: redirect wins.
        applyStimulus(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);
        checkOutput("redirStallCnt", 32'(bus.stall_cnt), 32'd2);
        checkOutput("redirFlushCnt", 32'(bus.flush_cnt), 32'd1);

        // MEM access acked on the fourth cycle; redirect held throughout.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Same-cycle ack costs nothing.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("zeroWaitState", 32'(bus.mem_wait), 32'd0);

        // Request held with no ack until the timeout releases it.
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("timeoutSticky", 32'(bus.timeout_err), 32'd1);

        // Reset while waiting abandons the access and clears the error.
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("inWaitBeforeRst", 32'(bus.mem_wait), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstClearsWait", 32'(bus.mem_wait), 32'd0);
        checkOutput("rstClearsErr", 32'(bus.timeout_err), 32'd0);

        // Saturation of the stall counter.
        repeat (CNT_MAX + 4) applyStimulus(0, 1, 3, 3, 0, 1, 0, 0, 0, 0);
        checkOutput("stallSaturated", 32'(bus.stall_cnt), 32'(CNT_MAX));

        // Randomized traffic; a started access keeps MEM_req high until it is released.
        pending = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (pending) begin
                req = 1'b1;
                ack = ($urandom_range(0, 3) == 0);
            end else begin
                req = ($urandom_range(0, 5) == 0);
                ack = req && ($urandom_range(0, 2) == 0);
            end
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                          1'($urandom), $urandom_range(0, 4) == 0, req, ack);
            pending = (mdlWait != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
